// File: rtl/nonce_work_scheduler.sv
// Nonce scheduler: issues one tagged nonce per hash_clk into the SHA-256 pipe; a matched delay line attributes matches to {nonce, job}.
// Latency: accept -> first nonce 1 cycle, slot -> match PIPE_LATENCY cycles; jobs always accepted (preempt), full match FIFO drops and flags overflow.

module nws_fifo #(
   parameter int W     = 36,
   parameter int DEPTH = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_vld_i,
   input  logic [W-1:0] push_dat_i,
   input  logic         pop_rdy_i,
   output logic         pop_vld_o,
   output logic [W-1:0] pop_dat_o,
   output logic         full_o
);
   // First-word-fall-through FIFO; DEPTH is a power of 2, at least 2.
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          empty;
   logic          push_ok;
   logic          pop_ok;

   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full_o    = ((wr_ptr_q - rd_ptr_q) == PW'(DEPTH));
   assign pop_vld_o = ~empty;
   assign pop_dat_o = mem_q[rd_ptr_q[AW-1:0]];
   assign pop_ok    = pop_rdy_i & ~empty;
   // A pop frees the slot in the same cycle, so push-at-full succeeds alongside it.
   assign push_ok   = push_vld_i & (~full_o | pop_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
      end
   end
endmodule

module nonce_work_scheduler #(
   parameter int PIPE_LATENCY = 256,
   parameter int JOB_ID_W     = 4,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                hash_clk_i,
   input  logic                reset_i,
   input  logic                job_valid_i,
   output logic                job_ready_o,
   input  logic [255:0]        job_midstate_i,
   input  logic [95:0]         job_data_i,
   input  logic [JOB_ID_W-1:0] job_id_i,
   input  logic [31:0]         job_nonce_start_i,
   input  logic [31:0]         job_nonce_end_i,
   output logic [255:0]        midstate_o,
   output logic [95:0]         data_o,
   output logic [31:0]         nonce_o,
   input  logic                hash_match_i,
   output logic                gn_valid_o,
   input  logic                gn_ready_i,
   output logic [31:0]         gn_nonce_o,
   output logic [JOB_ID_W-1:0] gn_job_id_o,
   output logic                gn_overflow_o,
   output logic                busy_o,
   output logic                range_done_o
);
   localparam int DW = $clog2(PIPE_LATENCY + 1);

   typedef enum logic {S_IDLE, S_RUN} state_e;

   typedef struct packed {
      logic [JOB_ID_W-1:0] job_id;
      logic [31:0]         nonce;
   } tag_t;

   state_e              state_q, state_d;
   logic [255:0]        midstate_q, midstate_d;
   logic [95:0]         data_q, data_d;
   logic [31:0]         nonce_q, nonce_d;
   logic [31:0]         end_q, end_d;
   logic [JOB_ID_W-1:0] id_q, id_d;
   logic                done_q, done_d;
   logic [DW-1:0]       drain_q, drain_d;
   logic                ovf_q, ovf_d;

   logic                    accept;
   logic                    slot_vld;
   tag_t                    slot_tag;
   logic [PIPE_LATENCY-1:0] dl_vld_q;
   tag_t                    dl_tag_q [PIPE_LATENCY];
   logic                    match_vld;
   tag_t                    gn_head;
   logic                    gn_full;

   assign job_ready_o = ~reset_i;
   assign accept      = job_valid_i & job_ready_o;
   assign slot_vld    = (state_q == S_RUN);
   assign slot_tag    = {id_q, nonce_q};

   always_comb begin
      state_d    = state_q;
      midstate_d = midstate_q;
      data_d     = data_q;
      nonce_d    = nonce_q;
      end_d      = end_q;
      id_d       = id_q;
      done_d     = 1'b0;
      if (state_q == S_RUN) begin
         if (nonce_q == end_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
         end else begin
            nonce_d = nonce_q + 32'd1;
         end
      end
      // A new job overrides range progression; a just-finished range still reports done.
      if (accept) begin
         state_d    = S_RUN;
         midstate_d = job_midstate_i;
         data_d     = job_data_i;
         nonce_d    = job_nonce_start_i;
         end_d      = job_nonce_end_i;
         id_d       = job_id_i;
      end
   end

   always_comb begin
      drain_d = drain_q;
      if (slot_vld)          drain_d = DW'(PIPE_LATENCY);
      else if (drain_q != 0) drain_d = drain_q - DW'(1);
   end

   assign match_vld = hash_match_i & dl_vld_q[PIPE_LATENCY-1];
   assign ovf_d     = ovf_q | (match_vld & gn_full & ~(gn_ready_i & gn_valid_o));

   always_ff @(posedge hash_clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         midstate_q <= '0;
         data_q     <= '0;
         nonce_q    <= '0;
         end_q      <= '0;
         id_q       <= '0;
         done_q     <= 1'b0;
         drain_q    <= '0;
         ovf_q      <= 1'b0;
         dl_vld_q   <= '0;
      end else begin
         state_q    <= state_d;
         midstate_q <= midstate_d;
         data_q     <= data_d;
         nonce_q    <= nonce_d;
         end_q      <= end_d;
         id_q       <= id_d;
         done_q     <= done_d;
         drain_q    <= drain_d;
         ovf_q      <= ovf_d;
         dl_vld_q   <= {dl_vld_q[PIPE_LATENCY-2:0], slot_vld};
      end
   end

   // Payload needs no reset: only the valid bits decide whether a match is reported.
   always_ff @(posedge hash_clk_i) begin
      dl_tag_q[0] <= slot_tag;
      for (int i = 1; i < PIPE_LATENCY; i++) dl_tag_q[i] <= dl_tag_q[i-1];
   end

   nws_fifo #(
      .W     ($bits(tag_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_gn_fifo (
      .clk_i      (hash_clk_i),
      .rst_i      (reset_i),
      .push_vld_i (match_vld),
      .push_dat_i (dl_tag_q[PIPE_LATENCY-1]),
      .pop_rdy_i  (gn_ready_i),
      .pop_vld_o  (gn_valid_o),
      .pop_dat_o  (gn_head),
      .full_o     (gn_full)
   );

   assign midstate_o    = midstate_q;
   assign data_o        = data_q;
   assign nonce_o       = nonce_q;
   assign range_done_o  = done_q;
   assign gn_overflow_o = ovf_q;
   assign gn_nonce_o    = gn_head.nonce;
   assign gn_job_id_o   = gn_head.job_id;
   assign busy_o        = (state_q == S_RUN) || (drain_q != 0);
endmodule
